cla_nibble_seq: RTL and testbench
=================================

# cla_nibble_seq

Multi-cycle wide adder/subtractor controller that time-multiplexes a single CLA4 slice across a WIDTH-bit operand, processing one nibble per clock. Operands are captured on a start handshake. The carry is registered between nibbles, and the full result is presented with a one-cycle Done pulse. It sits between a sequencing master (ALU/microcode controller) and the existing CLA4 datapath, trading latency for area on wide adds.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4 nibbles.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE or DONE.
- Sub  input  1  1 = A − B (B inverted, carry-in forced 1, Cin ignored); 0 = A + B + Cin.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in for add; captured on the accepting edge.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; result valid.
- S  output  WIDTH  registered result; holds until the next completion.
- Cout  output  1  carry out of bit WIDTH−1; for Sub, 1 = no borrow.
- Ovf  output  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - a_sh, b_sh: operand shift registers, B pre-inverted when Sub.
  - c_reg: inter-nibble carry.
  - cnt: nibble index, ceil(log2 NIB) bits.
  - s_sh: partial-sum shift register.
  - sign bits a_msb, b_msb (b_msb after inversion).
- IDLE/DONE with Start=1: latch operands, set c_reg = Sub ? 1 : Cin, cnt=0, go to RUN. Start=0: DONE→IDLE, IDLE holds.
- RUN, each edge:
  - Feed a_sh[3:0], b_sh[3:0], c_reg to CLA4.
  - Shift the CLA4 sum into s_sh from the top; shift a_sh/b_sh right by 4.
  - Load c_reg from CLA4 Cout; increment cnt.
- RUN with cnt = NIB−1 (last nibble): on the same edge load S from the final s_sh, Cout from the CLA4 carry, and Ovf = (a_msb == b_msb) && (S[WIDTH−1] != a_msb). Go to DONE.
- Start while Busy: ignored, no queuing; operand changes during RUN have no effect.
- S/Cout/Ovf change only at the completion edge; intermediate nibbles are never visible on S.
- Reset (any state, including mid-RUN): state=IDLE, Busy=0, Done=0, S=0, Cout=0, Ovf=0, cnt=0, c_reg=0, shift registers cleared. The in-flight operation is discarded with no Done.

## Timing
- Edge e0 samples Start → Busy=1 from after e0 until eNIB.
- Edges e1..eNIB process nibbles 0..NIB−1, one per edge.
- After eNIB: Busy=0, Done=1, S/Cout/Ovf valid. WIDTH=16 gives Done 4 cycles after the accepting edge.
- Done=1 for exactly one cycle (DONE state).
- Start=1 in DONE is accepted at e(NIB+1): back-to-back throughput is one operation per NIB+1 cycles, with Done and the new Busy in adjacent cycles.
- Outputs are Moore outputs, all registered or state-decoded; no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, A=0xFFFF, B=0x0001, Cin=0, Sub=0 → S=0x0000, Cout=1, Ovf=0; Done high exactly 4 cycles after the Start edge, for 1 cycle; Busy high for 4 cycles.
- A=0x7FFF, B=0x0001, Sub=0 → S=0x8000, Cout=0, Ovf=1.
- A=0x8000, B=0x0001, Sub=1, Cin=0 → S=0x7FFF, Cout=1, Ovf=1. Repeat with Cin=1 → identical result (Cin ignored).
- Start pulsed with A=0x1234, B=0x1111; during RUN drive Start=1 with A=0xFFFF → first result S=0x2345 only, single Done, no second operation.
- Assert RST at cycle 2 of RUN → all outputs 0 immediately (asynchronous), no Done. Then start A=0x0F0F, B=0x00F1 → S=0x1000, Cout=0.
- Back-to-back: hold Start=1 through DONE with new operands A=0x0003, B=0x0004 → second Done 5 cycles after the first, S=0x0007. The first S stays stable until then.

Source files
------------

// File: rtl/cla_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : cla_nibble_seq
// Description : Multi-cycle WIDTH-bit adder/subtractor that reuses a single
//               4-bit carry-lookahead slice, processing one nibble per clock
//               from least to most significant. Operands are captured on a
//               start handshake, the carry is registered between nibbles and
//               the full result is presented with a one-cycle done pulse.
// Ports       : clk   - clock, all state updates on the rising edge
//               rst   - asynchronous active-high reset
//               start - request, sampled only in IDLE or DONE
//               sub   - 1: a - b (b inverted, carry-in 1, cin ignored)
//                       0: a + b + cin
//               a, b  - operands, captured on the accepting edge
//               cin   - carry-in for add, captured on the accepting edge
//               busy  - high while nibbles are being processed
//               done  - one-cycle pulse, result valid
//               s     - registered result, held until the next completion
//               cout  - carry out of the top bit (sub: 1 = no borrow)
//               ovf   - signed two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_seq #(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int c_nib   = WIDTH / 4;
  localparam int c_cnt_w = (c_nib > 1) ? $clog2(c_nib) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nib - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_c;
  logic [c_cnt_w-1:0] r_cnt;
  // Holds only the nibbles already produced; the nibble being computed this
  // cycle is appended on top, so the low nibble slot is never needed.
  logic [WIDTH-5:0]   r_s_sh;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [3:0]         w_p;
  logic [3:0]         w_g;
  logic               w_c1;
  logic               w_c2;
  logic               w_c3;
  logic               w_c4;
  logic [3:0]         w_sum;
  logic [WIDTH-1:0]   w_s_next;
  logic [WIDTH-1:0]   w_b_in;

  // 4-bit carry-lookahead slice on the current low nibble.
  assign w_p = r_a_sh[3:0] ^ r_b_sh[3:0];
  assign w_g = r_a_sh[3:0] & r_b_sh[3:0];

  assign w_c1 = w_g[0] | (w_p[0] & r_c);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_c);
  assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);

  assign w_sum    = w_p ^ {w_c3, w_c2, w_c1, r_c};
  assign w_s_next = {w_sum, r_s_sh};

  // Subtraction is a + ~b + 1; inversion happens once at capture.
  assign w_b_in = sub ? ~b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_s_sh  <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_in;
            r_c     <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_s_sh  <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_in[WIDTH-1];
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_s_sh <= w_s_next[WIDTH-1:4];
          r_a_sh <= {4'b0000, r_a_sh[WIDTH-1:4]};
          r_b_sh <= {4'b0000, r_b_sh[WIDTH-1:4]};
          r_c    <= w_c4;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          // Last nibble: publish the whole result on this edge only, so the
          // visible outputs never show a partial sum.
          if (r_cnt == c_last) begin
            r_s     <= w_s_next;
            r_cout  <= w_c4;
            r_ovf   <= (r_a_msb == r_b_msb) && (w_s_next[WIDTH-1] != r_a_msb);
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_nibble_seq
// Description : Self-checking bench for cla_nibble_seq (WIDTH=16). Expected
//               results come from a signed/unsigned arithmetic model, are
//               queued when an operation is launched and popped on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];

  cla_nibble_seq #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .s    (s),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic, independent of any nibble structure.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    exp_t e;
    int   sa, sbv, r, ur;
    sa  = int'($signed(ma));
    sbv = int'($signed(mb));
    if (msub) begin
      r   = sa - sbv;
      e.c = (ma >= mb);
    end else begin
      r   = sa + sbv + int'(mcin);
      ur  = int'(ma) + int'(mb) + int'(mcin);
      e.c = (ur > 65535);
    end
    e.o = (r > 32767) || (r < -32768);
    e.s = 16'(r);
    return e;
  endfunction

  // Launch one operation, queue its expectation, wait (bounded) for done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        output int lat, output int bc,
                        output exp_t got, output exp_t exp_v,
                        output logic popped);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    sb.push_back(model(ta, tb_v, tcin, tsub));
    @(negedge clk);
    start = 1'b0;
    lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    got    = {s, cout, ovf};
    exp_v  = '0;
    popped = 1'b0;
    if (done === 1'b1 && sb.size() > 0) begin
      exp_v  = sb.pop_front();
      popped = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, s, cout, ovf} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", {busy, done, s, cout, ovf}, 20'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_add_wrap();
    int lat, bc; exp_t got, ev; logic p;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc, got, ev, p);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL wrap_busy_cycles got=%0d exp=4", bc); end
    total++;
    if (!p || got !== ev) begin
      bad++; $display("FAIL wrap_result got=%h exp=%h popped=%b", got, ev, p);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL wrap_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_add_ovf();
    int lat, bc; exp_t got, ev; logic p;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc, got, ev, p);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    total++;
    if (!p || got !== ev) begin
      bad++; $display("FAIL ovf_result got=%h exp=%h popped=%b", got, ev, p);
    end
  endtask

  task automatic test_sub();
    int lat, bc; exp_t got, ev; logic p;
    for (int k = 0; k < 2; k++) begin
      run_op(16'h8000, 16'h0001, k[0], 1'b1, lat, bc, got, ev, p);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL sub_latency cin=%0d got=%0d exp=4", k, lat); end
      total++;
      if (!p || got !== ev) begin
        bad++; $display("FAIL sub_result cin=%0d got=%h exp=%h popped=%b", k, got, ev, p);
      end
    end
    run_op(16'h1234, 16'h5678, 1'b1, 1'b1, lat, bc, got, ev, p);
    total++;
    if (!p || got !== ev) begin
      bad++; $display("FAIL sub_borrow got=%h exp=%h popped=%b", got, ev, p);
    end
  endtask

  task automatic test_start_ignored();
    int lat, extra; exp_t got, ev;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(model(16'h1234, 16'h1111, 1'b0, 1'b0));
    @(negedge clk);
    // Keep requesting with different operands while busy.
    a = 16'hFFFF;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    got = {s, cout, ovf};
    ev  = '0;
    if (sb.size() > 0) ev = sb.pop_front();
    total++;
    if (got !== ev) begin bad++; $display("FAIL ign_result got=%h exp=%h", got, ev); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ign_second_op got=%0d exp=0", extra); end
  endtask

  task automatic test_async_reset();
    int lat, bc, nd; exp_t got, ev; logic p;
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, s, cout, ovf} !== 20'h0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {busy, done, s, cout, ovf}, 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) nd++; end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", nd); end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat, bc, got, ev, p);
    total++;
    if (!p || got !== ev) begin
      bad++; $display("FAIL post_reset_result got=%h exp=%h popped=%b", got, ev, p);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n; exp_t got, ev; logic p, stable;
    logic [15:0] first_s;
    run_op(16'h0011, 16'h0022, 1'b0, 1'b0, lat, bc, got, ev, p);
    total++;
    if (!p || got !== ev) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h popped=%b", got, ev, p);
    end
    first_s = s;
    // Still in the done cycle: request the next operation immediately.
    a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b0));
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL b2b_adjacent got=%b exp=10", {busy, done});
    end
    start = 1'b0;
    n = 1; stable = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      if (s !== first_s) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL b2b_s_stable got=0 exp=1"); end
    total++;
    if (n !== 5) begin bad++; $display("FAIL b2b_spacing got=%0d exp=5", n); end
    got = {s, cout, ovf};
    ev  = '0;
    if (sb.size() > 0) ev = sb.pop_front();
    total++;
    if (got !== ev) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got, ev); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_add_ovf();
    test_sub();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
